axi_irq_ctrl: RTL

AXI4-lite slave interrupt aggregator that sits between SoC peripheral interrupt lines (UART, timer, future blocks) and one PicoRV32 irq input. It registers and edge/level-qualifies each source, latches pending bits, applies a per-source enable mask, and drives a single registered interrupt to the CPU. Firmware reads, masks and clears sources through the crossbar like any other peripheral.

---
 rtl/axi_irq_ctrl_if.sv | 36 +++
 rtl/axi_irq_ctrl.sv | 133 +++++++++++++
 2 files changed

// File: rtl/axi_irq_ctrl_if.sv
// AXI4-lite slave-side bus bundle for the interrupt aggregator.
// Signal names carry the i_/o_ direction as seen from the slave.
interface axi_irq_ctrl_if #(
  parameter int AXI_ADDR_BW_p = 12
);
  logic [AXI_ADDR_BW_p-1:0] i_axi_awaddr;
  logic                     i_axi_awvalid;
  logic [31:0]              i_axi_wdata;
  logic                     i_axi_wvalid;
  logic                     i_axi_bready;
  logic [AXI_ADDR_BW_p-1:0] i_axi_araddr;
  logic                     i_axi_arvalid;
  logic                     i_axi_rready;
  logic                     o_axi_awready;
  logic                     o_axi_wready;
  logic [1:0]               o_axi_bresp;
  logic                     o_axi_bvalid;
  logic                     o_axi_arready;
  logic [31:0]              o_axi_rdata;
  logic [1:0]               o_axi_rresp;
  logic                     o_axi_rvalid;

  modport slave (
    input  i_axi_awaddr, i_axi_awvalid, i_axi_wdata, i_axi_wvalid, i_axi_bready,
    input  i_axi_araddr, i_axi_arvalid, i_axi_rready,
    output o_axi_awready, o_axi_wready, o_axi_bresp, o_axi_bvalid,
    output o_axi_arready, o_axi_rdata, o_axi_rresp, o_axi_rvalid
  );

  modport master (
    output i_axi_awaddr, i_axi_awvalid, i_axi_wdata, i_axi_wvalid, i_axi_bready,
    output i_axi_araddr, i_axi_arvalid, i_axi_rready,
    input  o_axi_awready, o_axi_wready, o_axi_bresp, o_axi_bvalid,
    input  o_axi_arready, o_axi_rdata, o_axi_rresp, o_axi_rvalid
  );
endinterface

// File: rtl/axi_irq_ctrl.sv
// AXI4-lite interrupt aggregator: per-source edge/level qualify, pending latch,
// enable mask, one registered irq to the CPU. Map: PENDING/ENABLE/EDGE/ACTIVE.

module axi_irq_ctrl_src (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic en_we,
  input  logic edge_we,
  input  logic w1c,
  input  logic wbit,
  output logic pend,
  output logic en,
  output logic edge_mode
);
  logic src_q, src_qq, set;

  assign set = edge_mode ? (src_q & ~src_qq) : src_q;

  // set wins over a same-cycle W1C so an event arriving with the clear is kept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q     <= 1'b0;
      src_qq    <= 1'b0;
      pend      <= 1'b0;
      en        <= 1'b0;
      edge_mode <= 1'b0;
    end else begin
      src_q  <= src;
      src_qq <= src_q;
      pend   <= (pend & ~w1c) | set;
      if (en_we)   en        <= wbit;
      if (edge_we) edge_mode <= wbit;
    end
  end
endmodule

module axi_irq_ctrl #(
  parameter int AXI_ADDR_BW_p = 12,
  parameter int IRQ_NBR_p     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axi_irq_ctrl_if.slave        axi,
  input  logic [IRQ_NBR_p-1:0] i_irq_src,
  output logic                 o_irq
);
  localparam int IDX_W = AXI_ADDR_BW_p - 2;

  logic [IDX_W-1:0]     aw_idx, ar_idx;
  logic                 wr_acc, rd_acc, wr_ok;
  logic                 wr_pend, wr_en, wr_edge;
  logic [IRQ_NBR_p-1:0] wbits, pend_v, en_v, edge_v;
  logic                 bvalid_q, rvalid_q;
  logic [1:0]           bresp_q, rresp_q, rd_resp;
  logic [31:0]          rdata_q, rd_data;
  logic                 unused;

  assign aw_idx  = axi.i_axi_awaddr[AXI_ADDR_BW_p-1:2];
  assign ar_idx  = axi.i_axi_araddr[AXI_ADDR_BW_p-1:2];
  assign wbits   = axi.i_axi_wdata[IRQ_NBR_p-1:0];
  assign unused  = ^{axi.i_axi_wdata, axi.i_axi_awaddr[1:0], axi.i_axi_araddr[1:0]};

  // ready is a same-cycle grant: both channels must be presented together
  assign wr_acc  = axi.i_axi_awvalid & axi.i_axi_wvalid & ~bvalid_q;
  assign rd_acc  = axi.i_axi_arvalid & ~rvalid_q;
  assign wr_ok   = aw_idx < IDX_W'(3);
  assign wr_pend = wr_acc && aw_idx == IDX_W'(0);
  assign wr_en   = wr_acc && aw_idx == IDX_W'(1);
  assign wr_edge = wr_acc && aw_idx == IDX_W'(2);

  for (genvar g = 0; g < IRQ_NBR_p; g++) begin : g_src
    axi_irq_ctrl_src u_src (
      .clk       (clk),
      .rst_n     (rst_n),
      .src       (i_irq_src[g]),
      .en_we     (wr_en),
      .edge_we   (wr_edge),
      .w1c       (wr_pend & wbits[g]),
      .wbit      (wbits[g]),
      .pend      (pend_v[g]),
      .en        (en_v[g]),
      .edge_mode (edge_v[g])
    );
  end

  always_comb begin
    rd_data = '0;
    rd_resp = 2'b00;
    case (ar_idx)
      IDX_W'(0): rd_data = 32'(pend_v);
      IDX_W'(1): rd_data = 32'(en_v);
      IDX_W'(2): rd_data = 32'(edge_v);
      IDX_W'(3): rd_data = 32'(pend_v & en_v);
      default:   rd_resp = 2'b10;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      rvalid_q <= 1'b0;
      rresp_q  <= 2'b00;
      rdata_q  <= '0;
      o_irq    <= 1'b0;
    end else begin
      if (wr_acc) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? 2'b00 : 2'b10;
      end else if (axi.i_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      if (rd_acc) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_resp;
      end else if (axi.i_axi_rready) begin
        rvalid_q <= 1'b0;
      end
      o_irq <= |(pend_v & en_v);
    end
  end

  assign axi.o_axi_awready = wr_acc;
  assign axi.o_axi_wready  = wr_acc;
  assign axi.o_axi_bvalid  = bvalid_q;
  assign axi.o_axi_bresp   = bresp_q;
  assign axi.o_axi_arready = rd_acc;
  assign axi.o_axi_rvalid  = rvalid_q;
  assign axi.o_axi_rdata   = rdata_q;
  assign axi.o_axi_rresp   = rresp_q;
endmodule
